// File: rtl/clock_step_pkg.sv
// Shared types and widths for the clock step controller.
package clock_step_pkg;

   localparam int unsigned ADDR_W = 16;

   typedef enum logic [1:0] {
      ST_HALT       = 2'd0,
      ST_RUN        = 2'd1,
      ST_STEP_CYCLE = 2'd2,
      ST_STEP_INSTR = 2'd3
   } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, level debouncer and rising-edge pulse for a push button.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
   localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_pulse;

   // A new level is taken only after it has been seen DEBOUNCE_CYCLES times in a row.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_btn};
         r_pulse <= 1'b0;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(CNT_MAX)) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
            r_pulse <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/clock_step_controller.sv
// Run / single-cycle / single-instruction clock gating for a datapath.
// Optional breakpoint comparator enabled by CLOCK_STEP_BREAKPOINT_EN.
module clock_step_controller
   import clock_step_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic              i_oszClk,
   input  logic              i_nReset,
   input  logic              i_btnStep,
   input  logic              i_swInstrNCycle,
   input  logic              i_swStepNRun,
   input  logic              i_swEnableBreakpoint,
   input  logic [ADDR_W-1:0] i_breakpointAddress,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic              i_instrDone,
   output logic              o_cpuClkEn,
   output logic              o_halted,
   output logic              o_bpHit
);

   state_t     r_state;
   state_t     w_next;
   logic       r_bp_hit;
   logic       w_bp_hit_next;
   logic       r_cpu_clk_en;
   logic       r_halted;
   logic [1:0] r_sync_step;
   logic [1:0] r_sync_instr;
   logic [1:0] r_warm;
   logic       w_step_pulse;
   logic       w_step_mode;
   logic       w_instr_gran;
   logic       w_bp_match;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_step (
      .i_clk  (i_oszClk),
      .i_rst_n(i_nReset),
      .i_btn  (i_btnStep),
      .o_pulse(w_step_pulse)
   );

   // r_warm keeps HALT until the switch synchronizers hold real switch values.
   always_ff @(posedge i_oszClk or negedge i_nReset) begin
      if (!i_nReset) begin
         r_sync_step  <= '0;
         r_sync_instr <= '0;
         r_warm       <= '0;
      end else begin
         r_sync_step  <= {r_sync_step[0], i_swStepNRun};
         r_sync_instr <= {r_sync_instr[0], i_swInstrNCycle};
         r_warm       <= {r_warm[0], 1'b1};
      end
   end

   assign w_step_mode  = r_sync_step[1];
   assign w_instr_gran = r_sync_instr[1];

`ifdef CLOCK_STEP_BREAKPOINT_EN
   logic [1:0] r_sync_bpen;

   always_ff @(posedge i_oszClk or negedge i_nReset) begin
      if (!i_nReset) begin
         r_sync_bpen <= '0;
      end else begin
         r_sync_bpen <= {r_sync_bpen[0], i_swEnableBreakpoint};
      end
   end

   assign w_bp_match = r_sync_bpen[1] && (i_pc == i_breakpointAddress);
   assign o_bpHit    = r_bp_hit;
`else
   logic w_unused_bp;
   assign w_unused_bp = ^{i_swEnableBreakpoint, i_breakpointAddress, i_pc};
   assign w_bp_match  = 1'b0;
   assign o_bpHit     = 1'b0;
`endif

   // Outputs are registered from the next state so they track the state exactly.
   always_ff @(posedge i_oszClk or negedge i_nReset) begin
      if (!i_nReset) begin
         r_state      <= ST_HALT;
         r_bp_hit     <= 1'b0;
         r_cpu_clk_en <= 1'b0;
         r_halted     <= 1'b1;
      end else begin
         r_state      <= w_next;
         r_bp_hit     <= w_bp_hit_next;
         r_cpu_clk_en <= (w_next != ST_HALT);
         r_halted     <= (w_next == ST_HALT);
      end
   end

   always_comb begin
      w_next        = r_state;
      w_bp_hit_next = r_bp_hit;
      case (r_state)
         ST_HALT: begin
            if (r_warm[1]) begin
               if (w_step_mode) begin
                  if (w_step_pulse) begin
                     w_next = w_instr_gran ? ST_STEP_INSTR : ST_STEP_CYCLE;
                  end
               end else if (!r_bp_hit) begin
                  w_next = ST_RUN;
               end else if (w_step_pulse) begin
                  w_next        = ST_RUN;
                  w_bp_hit_next = 1'b0;
               end
            end
         end
         ST_RUN: begin
            if (i_instrDone && w_bp_match) begin
               w_next        = ST_HALT;
               w_bp_hit_next = 1'b1;
            end else if (i_instrDone && w_step_mode) begin
               w_next = ST_HALT;
            end
         end
         ST_STEP_CYCLE: w_next = ST_HALT;
         ST_STEP_INSTR: begin
            if (i_instrDone) begin
               w_next = ST_HALT;
            end
         end
         default: w_next = ST_HALT;
      endcase
   end

   assign o_cpuClkEn = r_cpu_clk_en;
   assign o_halted   = r_halted;

endmodule

// File: tb/tb_clock_step_controller.sv
// Randomized bench for clock_step_controller; a datapath model supplies i_pc / i_instrDone.
module tb_clock_step_controller;

   localparam int unsigned DEB = 4;

   logic        clk = 1'b0;
   logic        i_nReset;
   logic        i_btnStep;
   logic        i_swInstrNCycle;
   logic        i_swStepNRun;
   logic        i_swEnableBreakpoint;
   logic [15:0] i_breakpointAddress;
   logic [15:0] i_pc;
   logic        i_instrDone;
   logic        o_cpuClkEn;
   logic        o_halted;
   logic        o_bpHit;

   int          checks = 0;
   int          errors = 0;
   int          en_count;
   int          cyc = 0;
   int          first_en_cyc;
   bit          prev_en;
   int          lens [256];
   int          dp_idx;
   int          dp_cyc;
   logic [15:0] dp_base;

   always #5 clk = ~clk;

   clock_step_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
      .i_oszClk            (clk),
      .i_nReset            (i_nReset),
      .i_btnStep           (i_btnStep),
      .i_swInstrNCycle     (i_swInstrNCycle),
      .i_swStepNRun        (i_swStepNRun),
      .i_swEnableBreakpoint(i_swEnableBreakpoint),
      .i_breakpointAddress (i_breakpointAddress),
      .i_pc                (i_pc),
      .i_instrDone         (i_instrDone),
      .o_cpuClkEn          (o_cpuClkEn),
      .o_halted            (o_halted),
      .o_bpHit             (o_bpHit)
   );

   function automatic int cur_len();
      return lens[dp_idx % 256];
   endfunction

   function automatic int sum_lens(int n);
      int s = 0;
      for (int k = 0; k < n; k++) s += lens[k % 256];
      return s;
   endfunction

   // One clock: the datapath advances only over cycles that were enabled.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (prev_en) begin
         if (dp_cyc == cur_len() - 1) begin
            dp_cyc = 0;
            dp_idx++;
         end else begin
            dp_cyc++;
         end
      end
      prev_en = o_cpuClkEn;
      if (o_cpuClkEn) begin
         en_count++;
         if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      i_instrDone = o_cpuClkEn && (dp_cyc == cur_len() - 1);
      i_pc        = dp_base + 16'(dp_idx);
   endtask

   task automatic dp_setup(input logic [15:0] base, input int minl, input int maxl);
      for (int k = 0; k < 256; k++) lens[k] = int'($urandom_range(maxl, minl));
      dp_base      = base;
      dp_idx       = 0;
      dp_cyc       = 0;
      prev_en      = 1'b0;
      en_count     = 0;
      first_en_cyc = -1;
      i_instrDone  = 1'b0;
   endtask

   task automatic set_sw(input logic step_mode, input logic instr);
      i_swStepNRun    = step_mode;
      i_swInstrNCycle = instr;
      repeat (4) step();
   endtask

   task automatic press(input int hold);
      i_btnStep = 1'b1;
      repeat (hold) step();
      i_btnStep = 1'b0;
   endtask

   task automatic wait_halted(input logic want, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         if (o_halted == want) ok = 1'b1;
         else step();
      end
      if (o_halted == want) ok = 1'b1;
   endtask

   task automatic test_reset();
      i_nReset = 1'b0;
      repeat (3) step();
      checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b want 1", o_halted); end
      checks++; if (o_cpuClkEn !== 1'b0) begin errors++; $display("FAIL reset_clken: got %b want 0", o_cpuClkEn); end
      checks++; if (o_bpHit !== 1'b0) begin errors++; $display("FAIL reset_bphit: got %b want 0", o_bpHit); end
      i_nReset = 1'b1;
      dp_setup(16'h0000, 1, 1);
      repeat (20) step();
      checks++; if (en_count != 0) begin errors++; $display("FAIL release_step_mode_enables: got %0d want 0", en_count); end
      checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL release_step_mode_halted: got %b want 1", o_halted); end
   endtask

   task automatic test_step_cycle();
      int start;
      set_sw(1'b1, 1'b0);
      for (int it = 0; it < 4; it++) begin
         dp_setup(16'h0100, 1, 5);
         start = cyc;
         press((it == 0) ? 10 : int'($urandom_range(12, 6)));
         repeat (20) step();
         checks++; if (en_count != 1) begin errors++; $display("FAIL step_cycle_count[%0d]: got %0d want 1", it, en_count); end
         checks++;
         if (first_en_cyc < 0 || first_en_cyc - start > 8) begin
            errors++; $display("FAIL step_cycle_latency[%0d]: got %0d want 1..8", it, first_en_cyc - start);
         end
      end
   endtask

   task automatic test_step_instr();
      int n;
      set_sw(1'b1, 1'b1);
      for (int it = 0; it < 5; it++) begin
         n = (it == 0) ? 3 : int'($urandom_range(8, 1));
         dp_setup(16'h0010, n, n);
         press(8);
         repeat (n + 30) step();
         checks++; if (en_count != n) begin errors++; $display("FAIL step_instr_count[%0d]: got %0d want %0d", it, en_count, n); end
         checks++; if (dp_idx != 1 || o_halted !== 1'b1) begin
            errors++; $display("FAIL step_instr_end[%0d]: got instr %0d halted %b want 1 1", it, dp_idx, o_halted);
         end
      end
   endtask

   task automatic test_bounce();
      int seg;
      set_sw(1'b1, 1'b0);
      for (int it = 0; it < 3; it++) begin
         dp_setup(16'h0200, 1, 4);
         for (int k = 0; k < 20; k += seg) begin
            seg = (it == 0) ? 2 : int'($urandom_range(3, 1));
            i_btnStep = ~i_btnStep;
            repeat (seg) step();
         end
         press(12);
         repeat (20) step();
         checks++; if (en_count != 1) begin errors++; $display("FAIL bounce_count[%0d]: got %0d want 1", it, en_count); end
      end
   endtask

   task automatic test_switch_during_step();
      int  n;
      bit  ok;
      n = int'($urandom_range(24, 16));
      set_sw(1'b1, 1'b1);
      dp_setup(16'h0300, n, n);
      press(8);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         step();
         if (en_count > 0) ok = 1'b1;
      end
      checks++; if (!ok) begin errors++; $display("FAIL switch_step_start: got en %0d want >0", en_count); end
      i_swInstrNCycle = 1'b0;
      i_swStepNRun    = 1'b0;
      repeat (3) step();
      i_swStepNRun = 1'b1;
      press(6);
      repeat (n + 20) step();
      checks++; if (en_count != n) begin errors++; $display("FAIL switch_step_count: got %0d want %0d", en_count, n); end
      checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL switch_step_halted: got %b want 1", o_halted); end
   endtask

   task automatic test_run_stop();
      bit ok;
      set_sw(1'b1, 1'b0);
      for (int it = 0; it < 3; it++) begin
         dp_setup(16'h2000, 1, 6);
         i_swStepNRun = 1'b0;
         repeat ($urandom_range(60, 10)) step();
         press(8);
         checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL run_running[%0d]: got halted %b want 0", it, o_halted); end
         i_swStepNRun = 1'b1;
         wait_halted(1'b1, 20, ok);
         checks++; if (!ok) begin errors++; $display("FAIL run_stop_timeout[%0d]: got halted %b want 1", it, o_halted); end
         checks++;
         if (dp_cyc != 0 || en_count != sum_lens(dp_idx)) begin
            errors++; $display("FAIL run_stop_boundary[%0d]: got cyc %0d en %0d want 0 %0d", it, dp_cyc, en_count, sum_lens(dp_idx));
         end
      end
   endtask

   task automatic test_breakpoint();
      int k;
      int expected;
      bit ok;
      bit expect_bp;
      i_breakpointAddress = 16'h00FF;
      for (int it = 0; it < 2; it++) begin
`ifdef CLOCK_STEP_BREAKPOINT_EN
         expect_bp = (it == 0);
`else
         expect_bp = 1'b0;
`endif
         i_swEnableBreakpoint = (it == 0);
         set_sw(1'b1, 1'b0);
         k = int'($urandom_range(6, 1));
         dp_setup(16'h00FF - 16'(k), 1, 5);
         expected = sum_lens(k + 1);
         i_swStepNRun = 1'b0;
         wait_halted(1'b0, 10, ok);
         checks++; if (!ok) begin errors++; $display("FAIL bp_start[%0d]: got halted %b want 0", it, o_halted); end
         if (expect_bp) begin
            wait_halted(1'b1, expected + 20, ok);
            checks++; if (!ok || en_count != expected) begin
               errors++; $display("FAIL bp_halt[%0d]: got en %0d halted %b want %0d 1", it, en_count, o_halted, expected);
            end
            checks++; if (o_bpHit !== 1'b1) begin errors++; $display("FAIL bp_flag[%0d]: got %b want 1", it, o_bpHit); end
            repeat (10) step();
            checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL bp_stays_halted[%0d]: got %b want 1", it, o_halted); end
            press(8);
            repeat (10) step();
         end else begin
            repeat (expected + 15) step();
            checks++; if (dp_idx <= k) begin errors++; $display("FAIL bp_runthrough[%0d]: got instr %0d want >%0d", it, dp_idx, k); end
         end
         checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL bp_resumed[%0d]: got halted %b want 0", it, o_halted); end
         checks++; if (o_bpHit !== 1'b0) begin errors++; $display("FAIL bp_cleared[%0d]: got %b want 0", it, o_bpHit); end
         i_swStepNRun = 1'b1;
         wait_halted(1'b1, 20, ok);
         checks++; if (!ok) begin errors++; $display("FAIL bp_final_stop[%0d]: got halted %b want 1", it, o_halted); end
      end
   endtask

   task automatic test_reset_mid_step();
      bit ok;
      set_sw(1'b1, 1'b1);
      dp_setup(16'h0400, 20, 20);
      press(8);
      ok = 1'b0;
      for (int k = 0; k < 30 && !ok; k++) begin
         step();
         if (en_count >= 3) ok = 1'b1;
      end
      checks++; if (!ok || o_cpuClkEn !== 1'b1) begin errors++; $display("FAIL mid_step_active: got en %b want 1", o_cpuClkEn); end
      #1 i_nReset = 1'b0;
      #1;
      checks++; if (o_cpuClkEn !== 1'b0) begin errors++; $display("FAIL async_reset_clken: got %b want 0", o_cpuClkEn); end
      checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL async_reset_halted: got %b want 1", o_halted); end
      repeat (3) step();
      i_nReset = 1'b1;
      dp_setup(16'h0400, 20, 20);
      repeat (30) step();
      checks++; if (en_count != 0 || o_halted !== 1'b1) begin
         errors++; $display("FAIL after_reset_halt: got en %0d halted %b want 0 1", en_count, o_halted);
      end
   endtask

   initial begin
      i_nReset             = 1'b0;
      i_btnStep            = 1'b0;
      i_swInstrNCycle      = 1'b0;
      i_swStepNRun         = 1'b1;
      i_swEnableBreakpoint = 1'b0;
      i_breakpointAddress  = 16'h0000;
      i_instrDone          = 1'b0;
      i_pc                 = 16'h0000;
      dp_setup(16'h0000, 1, 1);
      test_reset();
      test_step_cycle();
      test_step_instr();
      test_bounce();
      test_switch_during_step();
      test_run_stop();
      test_breakpoint();
      test_reset_mid_step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_step_controller.md
CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive stable i_oszClk cycles required to accept a button level change.
REQ-002 The block SHALL have port i_oszClk, input, 1, system clock and the only clock.
REQ-003 The block SHALL have port i_nReset, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port i_btnStep, input, 1, raw step button, 1 = pressed.
REQ-005 The block SHALL have port i_swInstrNCycle, input, 1, step granularity: 1 = instruction, 0 = cycle.
REQ-006 The block SHALL have port i_swStepNRun, input, 1, mode: 1 = step, 0 = run.
REQ-007 The block SHALL have port i_swEnableBreakpoint, input, 1, breakpoint arm switch.
REQ-008 The block SHALL have port i_breakpointAddress, input, 16, breakpoint PC.
REQ-009 The block SHALL have port i_pc, input, 16, current program counter from the datapath.
REQ-010 The block SHALL have port i_instrDone, input, 1, high in the final cycle of an instruction.
REQ-011 The block SHALL have port o_cpuClkEn, output, 1, datapath clock enable.
REQ-012 The block SHALL have port o_halted, output, 1, high while in HALT.
REQ-013 The block SHALL have port o_bpHit, output, 1, sticky breakpoint-hit flag.

Function
REQ-014 All switch inputs and i_btnStep SHALL pass through 2-flop synchronizers before use.
REQ-015 The synchronized button SHALL be debounced: the level is accepted after DEBOUNCE_CYCLES identical samples, and a one-cycle stepPulse is produced on an accepted 0->1 transition only.
REQ-016 The FSM SHALL have the states HALT, RUN, STEP_CYCLE and STEP_INSTR.
REQ-017 In HALT: o_cpuClkEn=0; on stepPulse with step mode and cycle granularity the FSM SHALL go to STEP_CYCLE; with step mode and instruction granularity it SHALL go to STEP_INSTR.
REQ-018 In HALT with run mode: the FSM SHALL go to RUN if o_bpHit=0, otherwise only on stepPulse, which also clears o_bpHit.
REQ-019 In STEP_CYCLE: o_cpuClkEn=1 for exactly one cycle, then HALT.
REQ-020 In STEP_INSTR: o_cpuClkEn=1 up to and including the cycle with i_instrDone=1, then HALT.
REQ-021 In RUN: o_cpuClkEn=1; on step mode the FSM SHALL go to HALT at the next instruction boundary (i_instrDone=1).
REQ-022 In RUN, breakpoint: i_instrDone=1 and armed and i_pc==i_breakpointAddress SHALL cause HALT the next cycle and set o_bpHit; o_cpuClkEn stays 1 in that i_instrDone cycle.
REQ-023 Step pulses arriving outside HALT SHALL be ignored.
REQ-024 Switch changes during STEP_CYCLE or STEP_INSTR SHALL NOT abort the step.
REQ-025 o_cpuClkEn and o_halted SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-026 Asserting i_nReset low at any time, including mid-step, SHALL immediately force state=HALT, o_cpuClkEn=0, o_halted=1, o_bpHit=0, debounce counter=0, accepted button level=0 and synchronizers=0.

Configuration
REQ-027 With macro CLOCK_STEP_BREAKPOINT_EN defined, REQ-022 SHALL be implemented.
REQ-028 Without CLOCK_STEP_BREAKPOINT_EN, the comparator SHALL be absent, o_bpHit SHALL be tied 0, and i_swEnableBreakpoint, i_breakpointAddress and i_pc SHALL be unused.

Structure
REQ-029 The state enum (HALT, RUN, STEP_CYCLE, STEP_INSTR) and the 16-bit address width constant SHALL live in the shared package clock_step_pkg.
REQ-030 The synchronizer, debounce and edge detect SHALL be the sub-module button_debouncer, instantiated once for i_btnStep.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Release reset while in step mode -> o_halted=1, o_cpuClkEn=0; press step for 10 cycles in cycle mode -> exactly one o_cpuClkEn=1 cycle, within 2+4+2 cycles of the press.
REQ-032 Instruction mode, press step, drive i_instrDone high on the 3rd enabled cycle -> exactly 3 enable cycles, then HALT.
REQ-033 Run mode, armed, breakpoint 0x00FF, i_pc=0x00FF with i_instrDone=1 -> HALT next cycle, o_bpHit=1; a step press resumes RUN and clears o_bpHit.
REQ-034 Bouncy button (toggle every 2 cycles for 20 cycles, then held) -> exactly one step.
REQ-035 Assert i_nReset mid-STEP_INSTR -> o_cpuClkEn=0 in the same cycle with no clock edge needed; state HALT after release.
REQ-036 Build without CLOCK_STEP_BREAKPOINT_EN and repeat REQ-033 -> RUN continues and o_bpHit stays 0.
